// File: rtl/tsu_pkg.sv
// Shared definitions for the multi-channel timestamp queue: width helpers,
// overflow-policy encodings and the drop counter width.
package tsu_pkg;

    localparam int OVF_DROP_NEW = 0;
    localparam int OVF_DROP_OLD = 1;
    localparam int DROP_CNT_W   = 16;

    function automatic int tsu_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Channel-id width; a single-channel build still carries a 1-bit id
    function automatic int tsu_ch_w(input int num_ch);
        return (num_ch > 1) ? tsu_clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tsu_sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy. force_pop discards
// the head regardless of the read request so a full queue can be overwritten.
module tsu_sync_fifo import tsu_pkg::*; #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        force_pop,
    input  logic [WIDTH-1:0]            wr_data,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic [tsu_clog2(DEPTH):0]   usedw
);

    localparam int AW = tsu_clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;

    assign rd_valid = (usedw != '0);
    assign do_pop   = (pop | force_pop) & rd_valid;
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // Pointer and occupancy update; clear overrides any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            usedw <= usedw + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    // Storage array holds data only; empty slots are masked on the read side
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/tsu_queue_mc.sv
// Multi-channel timestamp queue: per-channel holding registers, a round-robin
// arbiter feeding one shared FIFO tagged with the source channel, drop
// accounting and a synchronous clear.
module tsu_queue_mc import tsu_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int INFO_W   = 52,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = OVF_DROP_NEW
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                q_clr,
    input  logic [NUM_CH-1:0]                   in_valid,
    input  logic [NUM_CH*INFO_W-1:0]            in_info,
    input  logic                                q_rd_en,
    output logic                                q_rd_valid,
    output logic [tsu_ch_w(NUM_CH)+INFO_W-1:0]  q_rd_data,
    output logic [tsu_clog2(DEPTH):0]           q_rd_usedw,
    output logic [DROP_CNT_W-1:0]               q_drop_cnt,
    output logic [NUM_CH-1:0]                   q_ovf_ch
);

    localparam int CH_W    = tsu_ch_w(NUM_CH);
    localparam int AW      = tsu_clog2(DEPTH);
    localparam int ENT_W   = CH_W + INFO_W;
    localparam int CNT_MAX = (1 << DROP_CNT_W) - 1;

    logic [NUM_CH-1:0] hold_vld_p0;
    logic [INFO_W-1:0] hold_info_p0 [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_ptr_nxt;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [NUM_CH-1:0] gnt_oh;
    logic              fifo_full;
    logic              rd_pop;
    logic              ovf_pop;
    logic [ENT_W-1:0]  fifo_wdata;
    logic [CH_W-1:0]   head_ch;
    logic [NUM_CH-1:0] drop_hold;
    logic [NUM_CH-1:0] ovf_set;
    int                drop_n;

    function automatic logic [DROP_CNT_W-1:0] sat_add_cnt(input logic [DROP_CNT_W-1:0] cnt,
                                                          input int inc);
        int sum;
        sum = int'(cnt) + inc;
        if (sum > CNT_MAX) return '1;
        return DROP_CNT_W'(sum);
    endfunction

    assign fifo_full  = (q_rd_usedw == (AW+1)'(DEPTH));
    assign rd_pop     = q_rd_en & q_rd_valid;
    assign head_ch    = q_rd_data[ENT_W-1 -: CH_W];
    assign ovf_pop    = gnt_vld & fifo_full & ~rd_pop;
    assign fifo_wdata = {gnt_ch, hold_info_p0[gnt_ch]};

    // Round-robin pick of the first full holding register at or after rr_ptr
    always_comb begin
        int idx;
        logic [CH_W-1:0] cidx;
        idx        = 0;
        cidx       = '0;
        gnt_vld    = 1'b0;
        gnt_ch     = '0;
        gnt_oh     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx  = (int'(rr_ptr) + k) % NUM_CH;
            cidx = CH_W'(idx);
            if (hold_vld_p0[cidx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cidx;
            end
        end
        // Drop-newest mode back-pressures into the holding stage when full
        if (fifo_full && !rd_pop && OVF_MODE != OVF_DROP_OLD) gnt_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_ch == CH_W'(i));
        end
        rr_ptr_nxt = CH_W'((int'(gnt_ch) + 1) % NUM_CH);
    end

    // Drop detection: busy ungranted holding slots plus an overwritten head
    always_comb begin
        drop_hold = in_valid & hold_vld_p0 & ~gnt_oh;
        ovf_set   = drop_hold;
        drop_n    = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_n = drop_n + int'(drop_hold[i]);
        end
        if (ovf_pop) begin
            drop_n = drop_n + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (head_ch == CH_W'(i)) ovf_set[i] = 1'b1;
            end
        end
    end

    // Holding stage: accept when empty or being drained this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_p0 <= '0;
            for (int i = 0; i < NUM_CH; i++) hold_info_p0[i] <= '0;
        end else if (q_clr) begin
            hold_vld_p0 <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_valid[i] && (!hold_vld_p0[i] || gnt_oh[i])) begin
                    hold_vld_p0[i]  <= 1'b1;
                    hold_info_p0[i] <= in_info[i*INFO_W +: INFO_W];
                end else if (gnt_oh[i]) begin
                    hold_vld_p0[i]  <= 1'b0;
                end
            end
        end
    end

    // Arbiter pointer, saturating drop counter and sticky per-channel flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            q_drop_cnt <= '0;
            q_ovf_ch   <= '0;
        end else if (q_clr) begin
            rr_ptr     <= '0;
            q_drop_cnt <= '0;
            q_ovf_ch   <= '0;
        end else begin
            if (gnt_vld) rr_ptr <= rr_ptr_nxt;
            q_drop_cnt <= sat_add_cnt(q_drop_cnt, drop_n);
            q_ovf_ch   <= q_ovf_ch | ovf_set;
        end
    end

    tsu_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (q_clr),
        .push      (gnt_vld),
        .pop       (q_rd_en),
        .force_pop (ovf_pop),
        .wr_data   (fifo_wdata),
        .rd_valid  (q_rd_valid),
        .rd_data   (q_rd_data),
        .usedw     (q_rd_usedw)
    );

endmodule

// File: tb/tb_tsu_queue_mc.sv
// Bench for tsu_queue_mc: one instance per overflow policy, scoreboard of
// expected {channel, record} entries checked at each pop.
`timescale 1ns/1ps
module tb_tsu_queue_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn [2];
    logic          clr  [2];
    logic [3:0]    vld  [2];
    logic [207:0]  info [2];
    logic          rd   [2];
    logic          rdv  [2];
    logic [53:0]   rdd  [2];
    logic [4:0]    used [2];
    logic [15:0]   drop [2];
    logic [3:0]    ovf  [2];

    logic [53:0] sbq0 [$];
    logic [53:0] sbq1 [$];

    int n_chk  = 0;
    int n_fail = 0;

    tsu_queue_mc #(.NUM_CH(4), .INFO_W(52), .DEPTH(16), .OVF_MODE(0)) dut_drop (
        .clk(clk), .rst_n(rstn[0]), .q_clr(clr[0]), .in_valid(vld[0]), .in_info(info[0]),
        .q_rd_en(rd[0]), .q_rd_valid(rdv[0]), .q_rd_data(rdd[0]), .q_rd_usedw(used[0]),
        .q_drop_cnt(drop[0]), .q_ovf_ch(ovf[0])
    );

    tsu_queue_mc #(.NUM_CH(4), .INFO_W(52), .DEPTH(16), .OVF_MODE(1)) dut_ovw (
        .clk(clk), .rst_n(rstn[1]), .q_clr(clr[1]), .in_valid(vld[1]), .in_info(info[1]),
        .q_rd_en(rd[1]), .q_rd_valid(rdv[1]), .q_rd_data(rdd[1]), .q_rd_usedw(used[1]),
        .q_drop_cnt(drop[1]), .q_ovf_ch(ovf[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [51:0] rec(input int ch, input int n);
        return {4'(ch), 16'hC0DE, 32'(n * 7919 + 1)};
    endfunction

    function automatic logic [53:0] ent(input int ch, input int n);
        return {2'(ch), rec(ch, n)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic [3:0] mask, input int n);
        vld[m] = mask;
        for (int c = 0; c < 4; c++) info[m][c*52 +: 52] = rec(c, n);
    endtask

    task automatic pop_chk(input int m, input string tag);
        logic [53:0] e;
        bit have;
        e = '0;
        have = 1'b0;
        chk({tag, "_vld"}, 64'(rdv[m]), 64'd1);
        if (m == 0) begin
            if (sbq0.size() > 0) begin have = 1'b1; e = sbq0.pop_front(); end
        end else begin
            if (sbq1.size() > 0) begin have = 1'b1; e = sbq1.pop_front(); end
        end
        if (have) begin
            chk({tag, "_data"}, 64'(rdd[m]), 64'(e));
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_sb: got data %0h, expected no entry", tag, rdd[m]);
        end
        rd[m] = 1'b1;
        tick();
        rd[m] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [53:0] e;
        for (int m = 0; m < 2; m++) begin
            rstn[m] = 1'b0; clr[m] = 1'b0; vld[m] = '0; info[m] = '0; rd[m] = 1'b0;
        end
        #1;
        // reset state
        chk("rst_vld",  64'(rdv[0]),  64'd0);
        chk("rst_used", 64'(used[0]), 64'd0);
        chk("rst_drop", 64'(drop[0]), 64'd0);
        chk("rst_ovf",  64'(ovf[0]),  64'd0);
        chk("rst_data", 64'(rdd[0]),  64'd0);
        chk("rst_used_b", 64'(used[1]), 64'd0);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        tick();

        // single record on channel 2, two-cycle latency
        vld[0] = 4'b0100;
        info[0][104 +: 52] = 52'h0_0000_1234_5678;
        sbq0.push_back({2'd2, 52'h0_0000_1234_5678});
        tick();
        vld[0] = '0;
        chk("t1_lat1", 64'(rdv[0]), 64'd0);
        tick();
        chk("t1_used", 64'(used[0]), 64'd1);
        pop_chk(0, "t1_pop");
        chk("t1_empty_used", 64'(used[0]), 64'd0);
        chk("t1_empty_vld",  64'(rdv[0]),  64'd0);

        // round robin starting at 0, then starting at 2
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        drive(0, 4'hF, 100);
        tick();
        vld[0] = '0;
        for (int c = 0; c < 4; c++) sbq0.push_back(ent(c, 100));
        repeat (4) tick();
        chk("t2_used", 64'(used[0]), 64'd4);
        for (int k = 0; k < 4; k++) pop_chk(0, "t2_rr0");
        drive(0, 4'b0010, 101);
        tick();
        vld[0] = '0;
        sbq0.push_back(ent(1, 101));
        tick();
        pop_chk(0, "t2_ch1");
        drive(0, 4'hF, 102);
        tick();
        vld[0] = '0;
        sbq0.push_back(ent(2, 102));
        sbq0.push_back(ent(3, 102));
        sbq0.push_back(ent(0, 102));
        sbq0.push_back(ent(1, 102));
        repeat (4) tick();
        for (int k = 0; k < 4; k++) pop_chk(0, "t2_rr2");
        chk("t2_end_used", 64'(used[0]), 64'd0);

        // drop-newest: back-pressure into hold, second strobe dropped
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int n = 0; n < 16; n++) begin
            drive(0, 4'b0001, 200 + n);
            sbq0.push_back(ent(0, 200 + n));
            tick();
        end
        vld[0] = '0;
        tick();
        chk("t3_full", 64'(used[0]), 64'd16);
        drive(0, 4'b0010, 300);
        tick();
        drive(0, 4'b0010, 301);
        tick();
        vld[0] = '0;
        tick();
        chk("t3_drop", 64'(drop[0]), 64'd1);
        chk("t3_ovf",  64'(ovf[0]),  64'h2);
        chk("t3_used", 64'(used[0]), 64'd16);
        pop_chk(0, "t3_pop");
        sbq0.push_back(ent(1, 300));
        chk("t3_refill", 64'(used[0]), 64'd16);
        for (int k = 0; k < 16; k++) pop_chk(0, "t3_drain");
        chk("t3_drained", 64'(used[0]), 64'd0);
        chk("t3_drop_end", 64'(drop[0]), 64'd1);

        // overwrite-oldest: head discarded, its channel flagged
        for (int n = 0; n < 16; n++) begin
            drive(1, 4'b1000, 400 + n);
            sbq1.push_back(ent(3, 400 + n));
            tick();
        end
        vld[1] = '0;
        tick();
        chk("t4_full", 64'(used[1]), 64'd16);
        drive(1, 4'b0001, 500);
        tick();
        vld[1] = '0;
        tick();
        chk("t4_used", 64'(used[1]), 64'd16);
        chk("t4_drop", 64'(drop[1]), 64'd1);
        chk("t4_ovf",  64'(ovf[1]),  64'h8);
        void'(sbq1.pop_front());
        sbq1.push_back(ent(0, 500));
        for (int k = 0; k < 16; k++) pop_chk(1, "t4_drain");
        chk("t4_drained", 64'(used[1]), 64'd0);

        // full with simultaneous read and write across pointer wrap
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int n = 0; n < 17; n++) begin
            drive(0, 4'b0100, 600 + n);
            sbq0.push_back(ent(2, 600 + n));
            tick();
        end
        vld[0] = '0;
        chk("t5_full", 64'(used[0]), 64'd16);
        for (int j = 0; j < 40; j++) begin
            drive(0, 4'b0100, 700 + j);
            sbq0.push_back(ent(2, 700 + j));
            e = sbq0.pop_front();
            chk("t5_data", 64'(rdd[0]), 64'(e));
            rd[0] = 1'b1;
            tick();
            chk("t5_used", 64'(used[0]), 64'd16);
        end
        rd[0] = 1'b0;
        vld[0] = '0;
        chk("t5_nodrop", 64'(drop[0]), 64'd0);
        for (int k = 0; k < 40 && rdv[0]; k++) pop_chk(0, "t5_drain");
        chk("t5_sb_left", 64'(sbq0.size()), 64'd0);
        chk("t5_empty", 64'(used[0]), 64'd0);

        // synchronous clear mid-burst
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        drive(0, 4'hF, 800);
        tick();
        drive(0, 4'hF, 801);
        tick();
        vld[0] = '0;
        repeat (3) tick();
        drive(0, 4'b0100, 802);
        tick();
        vld[0] = '0;
        chk("t6_pre_used", 64'(used[0]), 64'd5);
        chk("t6_pre_drop", 64'(drop[0]), 64'd3);
        chk("t6_pre_ovf",  64'(ovf[0]),  64'hE);
        clr[0] = 1'b1;
        drive(0, 4'hF, 803);
        rd[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        vld[0] = '0;
        rd[0] = 1'b0;
        chk("t6_used", 64'(used[0]), 64'd0);
        chk("t6_vld",  64'(rdv[0]),  64'd0);
        chk("t6_drop", 64'(drop[0]), 64'd0);
        chk("t6_ovf",  64'(ovf[0]),  64'd0);
        repeat (3) tick();
        chk("t6_lost", 64'(used[0]), 64'd0);
        sbq0.delete();

        // asynchronous reset pulse mid-burst
        drive(1, 4'b0010, 900);
        tick();
        drive(1, 4'b0010, 901);
        tick();
        vld[1] = '0;
        tick();
        chk("t7_pre_used", 64'(used[1]), 64'd2);
        #2;
        rstn[1] = 1'b0;
        #1;
        chk("t7_used", 64'(used[1]), 64'd0);
        chk("t7_vld",  64'(rdv[1]),  64'd0);
        chk("t7_drop", 64'(drop[1]), 64'd0);
        chk("t7_ovf",  64'(ovf[1]),  64'd0);
        chk("t7_data", 64'(rdd[1]),  64'd0);
        rstn[1] = 1'b1;
        sbq1.delete();
        tick();
        drive(1, 4'b0100, 950);
        tick();
        vld[1] = '0;
        sbq1.push_back(ent(2, 950));
        tick();
        pop_chk(1, "t7_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
